// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types: request/response structs, size/length/burst encodings
// and the requester slot assignment used by the cbus arbiter.
package cbus_arbiter_pkg;

    localparam int AXI_BURST_LEN = 16;

    localparam int CBUS_NUM_REQ   = 2;
    localparam int CBUS_ID_ICACHE = 0;
    localparam int CBUS_ID_DCACHE = 1;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Encoded as beats-1, matching AXI AxLEN.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        msize_t      size;
        mlen_t       len;
        axi_burst_t  burst;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Cache-side and bridge-side bundle of the cbus arbiter; master is the arbiter's
// view, slave is the view of the caches plus bridge around it.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = CBUS_NUM_REQ,
    localparam int IDX_BITS = $clog2(NUM_REQ)
) ();

    cbus_req_t  [NUM_REQ-1:0] ireqs;
    cbus_resp_t [NUM_REQ-1:0] iresps;
    cbus_req_t                oreq;
    cbus_resp_t               oresp;
    logic [IDX_BITS-1:0]      grant_idx;
    logic                     busy;

    modport master (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output grant_idx,
        output busy
    );

    modport slave (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  grant_idx,
        input  busy
    );

endinterface

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin first-set finder: nearest valid index at or after rr_ptr_i, wrapping.
// Purely combinational.
module cbus_arbiter_rr_select #(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid_i,
    input  logic [IDX_BITS-1:0] rr_ptr_i,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                any_o
);

    logic [IDX_BITS-1:0] cand;

    // Scan farthest-first so the closest valid index to rr_ptr_i wins last.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_BITS'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (valid_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus master port; one-cycle arbitration, grant held to ready&&last.
// Losers see ready=0 and simply wait; granted path is a combinational pass-through both ways.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = CBUS_NUM_REQ,
    localparam int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.master bus
);

    arb_state_e          state_q;
    logic [IDX_BITS-1:0] grant_q;
    logic [IDX_BITS-1:0] rr_ptr_q;
    logic [IDX_BITS-1:0] rr_ptr_d;
    logic [IDX_BITS-1:0] sel_idx;
    logic [NUM_REQ-1:0]  req_vld;
    logic                sel_any;
    logic                txn_done;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_vld
        assign req_vld[i] = bus.ireqs[i].valid;
    end

    cbus_arbiter_rr_select #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_select (
        .valid_i  (req_vld),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (sel_idx),
        .any_o    (sel_any)
    );

    assign rr_ptr_d = (grant_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_q + IDX_BITS'(1);

    // A granted requester dropping valid mid-burst releases the grant like a final beat.
    assign txn_done = !bus.ireqs[grant_q].valid || (bus.oresp.ready && bus.oresp.last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (sel_any) begin
                        grant_q <= sel_idx;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (txn_done) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.oreq   = '0;
        bus.iresps = '0;
        if (state_q == ARB_BUSY) begin
            bus.oreq            = bus.ireqs[grant_q];
            bus.iresps[grant_q] = bus.oresp;
        end
    end

    assign bus.busy      = (state_q == ARB_BUSY);
    assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant rules.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = CBUS_NUM_REQ;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bit m_busy;
    int m_grant;
    int m_rr;

    cbus_arbiter_if #(.NUM_REQ(N)) bus ();

    cbus_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.ireqs = '0;
        bus.oresp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic cbus_req_t mk_req(logic wr, logic [31:0] addr, msize_t sz, mlen_t ln);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.size     = sz;
        r.len      = ln;
        r.burst    = (ln == MLEN1) ? AXI_BURST_FIXED : AXI_BURST_INCR;
        r.strobe   = wr ? 8'hFF : 8'h00;
        r.data     = {addr, ~addr};
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(logic rdy, logic lst, logic [63:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.oresp = mk_resp(1'b1, 1'b1, 64'hBAD);
        tick();
        tick();
        sample();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.grant_idx !== '0) begin errors++; $display("FAIL reset_grant: got %0d want 0", bus.grant_idx); end
        checks++; if (bus.oreq !== '0) begin errors++; $display("FAIL reset_oreq: got %h want 0", bus.oreq); end
        checks++; if (bus.iresps !== '0) begin errors++; $display("FAIL reset_iresps: got %h want 0", bus.iresps); end
        tick();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        cbus_req_t   rq;
        logic [63:0] want_d;
        do_reset();
        rq = mk_req(1'b0, 32'h4060_0004, MSIZE4, MLEN1);
        bus.ireqs[CBUS_ID_DCACHE] = rq;
        sample();
        checks++; if (bus.oreq.valid !== 1'b0) begin errors++; $display("FAIL rd_decide_valid: got %b want 0", bus.oreq.valid); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) bus.oresp = mk_resp(1'b1, 1'b1, 64'hDEAD);
            else        bus.oresp = '0;
            if (c == 4) bus.ireqs[CBUS_ID_DCACHE] = '0;
            sample();
            if (c < 4) begin
                checks++;
                if (bus.oreq !== rq || bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin
                    errors++; $display("FAIL rd_pass c%0d: oreq=%h busy=%b grant=%0d want oreq=%h busy=1 grant=1", c, bus.oreq, bus.busy, bus.grant_idx, rq);
                end
            end else begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_drop: got %b want 0", bus.busy); end
            end
            want_d = (c == 3) ? 64'hDEAD : 64'h0;
            checks++; if (bus.iresps[1].data !== want_d) begin errors++; $display("FAIL rd_data c%0d: got %h want %h", c, bus.iresps[1].data, want_d); end
            checks++; if (bus.iresps[0] !== '0) begin errors++; $display("FAIL rd_icache_quiet c%0d: got %h want 0", c, bus.iresps[0]); end
        end
    endtask

    task automatic test_simul_burst();
        cbus_req_t rq_i, rq_d;
        rq_i = mk_req(1'b0, 32'h0000_1000, MSIZE8, MLEN16);
        rq_d = mk_req(1'b0, 32'h4060_0008, MSIZE4, MLEN1);
        reset = 1'b1;
        clear_inputs();
        bus.ireqs[0] = rq_i;
        bus.ireqs[1] = rq_d;
        tick();
        tick();
        reset = 1'b0;
        sample();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sim_decide_busy: got %b want 0", bus.busy); end
        for (int b = 0; b < AXI_BURST_LEN; b++) begin
            tick();
            bus.oresp = mk_resp(1'b1, b == AXI_BURST_LEN - 1, 64'(b) + 64'd100);
            sample();
            checks++;
            if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b0 || bus.oreq !== rq_i) begin
                errors++; $display("FAIL sim_beat%0d_grant: busy=%b grant=%0d oreq=%h want busy=1 grant=0", b, bus.busy, bus.grant_idx, bus.oreq);
            end
            checks++;
            if (bus.iresps[0].data !== 64'(b) + 64'd100 || bus.iresps[0].ready !== 1'b1 || bus.iresps[1] !== '0) begin
                errors++; $display("FAIL sim_beat%0d_resp: r0=%h r1=%h want r0.data=%0d r1=0", b, bus.iresps[0], bus.iresps[1], b + 100);
            end
        end
        tick();
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        sample();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sim_bubble: busy=%b want 0", bus.busy); end
        tick();
        sample();
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1 || bus.oreq !== rq_d) begin
            errors++; $display("FAIL sim_dcache_grant: busy=%b grant=%0d want busy=1 grant=1", bus.busy, bus.grant_idx);
        end
        tick();
        bus.oresp = mk_resp(1'b1, 1'b1, 64'h1234);
        sample();
        checks++; if (bus.iresps[1].ready !== 1'b1) begin errors++; $display("FAIL sim_dcache_ready: got %b want 1", bus.iresps[1].ready); end
        tick();
        bus.oresp    = '0;
        bus.ireqs[0] = rq_i;
        bus.ireqs[1] = rq_d;
        sample();
        tick();
        sample();
        checks++; if (bus.grant_idx !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL sim_rr_wrap: grant=%0d busy=%b want grant=0 busy=1", bus.grant_idx, bus.busy); end
    endtask

    task automatic test_burst_lock();
        cbus_req_t rq_w, rq_i;
        rq_w = mk_req(1'b1, 32'h8000_0040, MSIZE8, MLEN16);
        rq_i = mk_req(1'b0, 32'h0000_2000, MSIZE8, MLEN16);
        do_reset();
        bus.ireqs[1] = rq_w;
        sample();
        for (int b = 0; b < AXI_BURST_LEN; b++) begin
            tick();
            if (b == 2) bus.ireqs[0] = rq_i;
            bus.oresp = mk_resp(1'b1, b == AXI_BURST_LEN - 1, 64'hC0DE_0000 + 64'(b));
            sample();
            checks++;
            if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1 || bus.oreq !== rq_w) begin
                errors++; $display("FAIL lock_beat%0d: busy=%b grant=%0d oreq=%h want grant=1 oreq=%h", b, bus.busy, bus.grant_idx, bus.oreq, rq_w);
            end
            checks++; if (bus.iresps[0] !== '0) begin errors++; $display("FAIL lock_icache_wait%0d: got %h want 0", b, bus.iresps[0]); end
        end
        tick();
        bus.ireqs[1] = '0;
        bus.oresp    = '0;
        sample();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lock_bubble: busy=%b want 0", bus.busy); end
        tick();
        sample();
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b0 || bus.oreq !== rq_i) begin
            errors++; $display("FAIL lock_icache_grant: busy=%b grant=%0d want busy=1 grant=0", bus.busy, bus.grant_idx);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        do_reset();
        bus.ireqs[0] = mk_req(1'b0, 32'h0000_3000, MSIZE4, MLEN1);
        bus.ireqs[1] = mk_req(1'b0, 32'h4000_3000, MSIZE4, MLEN1);
        bus.oresp    = mk_resp(1'b1, 1'b1, 64'h5A);
        for (int c = 0; c < 40 && seq.size() < 6; c++) begin
            sample();
            if (bus.busy === 1'b1) seq.push_back(int'(bus.grant_idx));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= seq.size()) begin
                errors++; $display("FAIL fair_grant%0d: got none within budget want %0d", i, i % 2);
            end else if (seq[i] != i % 2) begin
                errors++; $display("FAIL fair_grant%0d: got %0d want %0d", i, seq[i], i % 2);
            end
        end
        clear_inputs();
    endtask

    task automatic test_abort_reset();
        cbus_req_t rq_i, rq_d;
        rq_i = mk_req(1'b0, 32'h0000_4000, MSIZE8, MLEN16);
        rq_d = mk_req(1'b1, 32'h4000_4000, MSIZE8, MLEN16);
        do_reset();
        bus.ireqs[0] = rq_i;
        sample();
        tick();
        bus.oresp = mk_resp(1'b1, 1'b0, 64'h1);
        sample();
        tick();
        sample();
        tick();
        bus.ireqs[0] = '0;
        bus.ireqs[1] = rq_d;
        bus.oresp    = '0;
        sample();
        checks++; if (bus.busy !== 1'b1 || bus.oreq.valid !== 1'b0) begin errors++; $display("FAIL abort_cycle: busy=%b oreq.valid=%b want 1/0", bus.busy, bus.oreq.valid); end
        tick();
        bus.ireqs[0] = rq_i;
        sample();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b want 0", bus.busy); end
        tick();
        sample();
        checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin errors++; $display("FAIL abort_rr: busy=%b grant=%0d want 1/1", bus.busy, bus.grant_idx); end
        tick();
        reset     = 1'b1;
        bus.oresp = mk_resp(1'b1, 1'b0, 64'd77);
        sample();
        tick();
        sample();
        checks++; if (bus.oreq.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_oreq: valid=%b busy=%b want 0/0", bus.oreq.valid, bus.busy); end
        checks++; if (bus.iresps !== '0) begin errors++; $display("FAIL rst_mid_iresps: got %h want 0", bus.iresps); end
        tick();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        bus.ireqs[0] = mk_req(1'b0, 32'h0000_5000, MSIZE4, MLEN1);
        sample();
        tick();
        bus.oresp = mk_resp(1'b1, 1'b1, 64'h77);
        sample();
        tick();
        bus.ireqs = '0;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++; if (bus.iresps !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle%0d: iresps=%h busy=%b want 0/0", k, bus.iresps, bus.busy); end
            tick();
        end
        bus.ireqs[0] = mk_req(1'b0, 32'h0000_5008, MSIZE4, MLEN1);
        bus.ireqs[1] = mk_req(1'b0, 32'h4000_5008, MSIZE4, MLEN1);
        bus.oresp    = '0;
        sample();
        tick();
        sample();
        checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin errors++; $display("FAIL spur_rr_kept: busy=%b grant=%0d want 1/1", bus.busy, bus.grant_idx); end
        clear_inputs();
    endtask

    task automatic test_random();
        cbus_req_t                exp_oreq;
        cbus_resp_t [N-1:0]       exp_resp;
        bit                       found;
        do_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_rr    = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(m_busy && i == m_grant && bus.ireqs[i].valid && $urandom_range(0, 19) != 0)) begin
                    if ($urandom_range(0, 3) != 0)
                        bus.ireqs[i] = mk_req(1'($urandom_range(0, 1)), $urandom, msize_t'($urandom_range(0, 3)),
                                              ($urandom_range(0, 1) != 0) ? MLEN16 : MLEN1);
                    else
                        bus.ireqs[i] = '0;
                end
            end
            bus.oresp = mk_resp(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, {$urandom, $urandom});
            sample();
            exp_oreq = '0;
            exp_resp = '0;
            if (m_busy) begin
                exp_oreq          = bus.ireqs[m_grant];
                exp_resp[m_grant] = bus.oresp;
            end
            checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd%0d_busy: got %b want %b", cyc, bus.busy, m_busy); end
            if (m_busy) begin
                checks++; if (int'(bus.grant_idx) != m_grant) begin errors++; $display("FAIL rnd%0d_grant: got %0d want %0d", cyc, bus.grant_idx, m_grant); end
            end
            checks++; if (bus.oreq !== exp_oreq) begin errors++; $display("FAIL rnd%0d_oreq: got %h want %h", cyc, bus.oreq, exp_oreq); end
            checks++; if (bus.iresps !== exp_resp) begin errors++; $display("FAIL rnd%0d_iresps: got %h want %h", cyc, bus.iresps, exp_resp); end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!found && bus.ireqs[c].valid) begin
                        found   = 1'b1;
                        m_grant = c;
                    end
                end
                if (found) m_busy = 1'b1;
            end else if (!bus.ireqs[m_grant].valid || (bus.oresp.ready && bus.oresp.last)) begin
                m_busy = 1'b0;
                m_rr   = (m_grant + 1) % N;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simul_burst();
        test_burst_lock();
        test_fairness();
        test_abort_reset();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single cache-bus master port (cbus_req_t / cbus_resp_t) between NUM_REQ cache-side requesters, for example ICache and DCache.
- Sits between the caches and the cbus-to-AXI bridge.
- Uses round-robin priority.
- Locks a grant for the whole transaction, including multi-beat INCR bursts for line fetch and writeback, until the final beat completes.

Parameters:
- NUM_REQ, 2, number of requester ports (>=2).
- IDX_BITS, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  reset
- ireqs  input  NUM_REQ x cbus_req_t  requests from caches; index 0 = ICache, 1 = DCache
- iresps  output  NUM_REQ x cbus_resp_t  per-requester responses
- oreq  output  cbus_req_t  request to the bus bridge
- oresp  input  cbus_resp_t  response from the bus bridge
- grant_idx  output  IDX_BITS  currently granted requester (valid only when busy=1)
- busy  output  1  a transaction is in flight

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- State machine: IDLE, BUSY. Registers: state, grant_idx, rr_ptr (IDX_BITS).
- Reset values: state=IDLE, grant_idx=0, rr_ptr=0, busy=0, oreq all-zero (valid=0), every iresps[i] all-zero.
- IDLE:
  - If any ireqs[i].valid, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index into grant_idx and go to BUSY.
  - Arbitration costs exactly one cycle: oreq.valid is 0 in the decision cycle.
  - No valid request: stay in IDLE.
- BUSY:
  - oreq = ireqs[grant_idx] combinationally; all fields pass through unmodified.
  - iresps[grant_idx] = oresp.
  - Every other iresps[j] = all-zero (ready=0, last=0, data=0).
- Completion: on a cycle with oresp.ready && oresp.last in BUSY, next state is IDLE and rr_ptr <= grant_idx+1 (wraps to 0 at NUM_REQ-1).
  - Earliest re-grant is the cycle after IDLE is entered. This gives a one-cycle bubble between transactions, which is required so requesters can update their state.
- Abort: if ireqs[grant_idx].valid is 0 in BUSY, release the grant (next state IDLE, rr_ptr <= grant_idx+1).
  - oreq.valid is 0 that cycle because it passes through.
- Requester obligations (not checked): hold every request field stable from valid=1 until ready&&last. Beats are counted by the requester.
- A non-granted requester may assert or deassert valid at any time. It sees ready=0 and waits.
- Simultaneous events:
  - A new request arriving in the completion cycle is not granted until the following IDLE cycle.
  - oresp.ready with last=0 only forwards the beat; the grant is unchanged.
- busy = (state==BUSY).
- oresp is ignored in IDLE: iresps is all-zero even if oresp.ready is spuriously 1.
- Reset mid-burst: return to IDLE immediately. oreq.valid=0 in the cycle after reset is sampled. The bridge is reset by the same signal.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 transactions.

Decomposition:
- cbus_req_t, cbus_resp_t, msize/mlen/burst enums and AXI_BURST_LEN stay in the common package.
- Add to common: localparam CBUS_NUM_REQ = 2, and the requester index constants CBUS_ID_ICACHE = 0 and CBUS_ID_DCACHE = 1.
- One natural sub-module: rr_select, a combinational round-robin first-set finder. Inputs are a valid vector and rr_ptr; outputs are the index and an any flag.
- The state machine and muxing live in cbus_arbiter.

Test Plan:
1. Single DCache uncached read:
   - Stimulus: ireqs[1] valid, addr 0x40600004, MLEN1, MSIZE4; bridge returns ready=1, last=1, data 0xDEAD after 3 cycles.
   - Response: oreq.valid rises 1 cycle after request; iresps[1].data=0xDEAD for exactly one cycle; iresps[0] stays zero; busy drops the next cycle.
2. Simultaneous requests after reset:
   - Stimulus: both requesters valid from reset release.
   - Response: ICache (0) granted first. After its 16-beat INCR burst ends with last, DCache (1) is granted after a one-cycle bubble. rr_ptr ends at 0.
3. Burst lock:
   - Stimulus: DCache in a writeback burst (is_write=1, AXI_BURST_LEN beats); ICache asserts valid at beat 3.
   - Response: oreq stays DCache for all beats; ICache sees ready=0 throughout; ICache is granted only after DCache's last beat.
4. Fairness:
   - Stimulus: both requesters continuously valid for 6 single-beat transactions.
   - Response: grant sequence is 0,1,0,1,0,1.
5. Abort and reset:
   - Abort stimulus: granted requester drops valid mid-burst. Response: IDLE next cycle, rr_ptr advanced.
   - Reset stimulus: reset asserted during BUSY. Response: oreq.valid=0 and all iresps zero the cycle after reset is sampled.
6. Spurious response:
   - Stimulus: oresp.ready=1, last=1 while IDLE.
   - Response: no iresps[i].ready asserted; rr_ptr unchanged.
